lut_reverse_search: RTL and testbench
=====================================

// Module: lut_reverse_search
// PURPOSE
//  Inverse of the branch-target lookup table: given an 11-bit target PC, returns the 5-bit table index holding it.
//  Owns a writable 32-entry target table; entries 0-7 reset to the standard branch targets.
//  Keeps a combinational forward read port (index -> target).
//  Sits beside the fetch/branch logic; the loader/assembler-support path uses it to encode targets and to reprogram entries.
// PARAMETERS
//  ADDR_W  5   index width; DEPTH = 2**ADDR_W, max 32 entries
//  TGT_W   11  target PC width
// PORTS
//  CLK        in   1       single clock, rising edge
//  Reset_n    in   1       synchronous, active-low reset
//  WrEn       in   1       table write strobe
//  WrValid    in   1       valid bit written with entry (0 = invalidate)
//  WrAddr     in   ADDR_W  entry to write
//  WrTarget   in   TGT_W   target value to write
//  RdAddr     in   ADDR_W  forward lookup index
//  RdTarget   out  TGT_W   comb: table[RdAddr] if valid, else 0
//  ReqValid   in   1       reverse-search request
//  ReqTarget  in   TGT_W   key to search for
//  ReqReady   out  1       high only in IDLE
//  RspValid   out  1       result valid, held until RspAck
//  RspHit     out  1       1 = key found
//  RspAddr    out  ADDR_W  lowest matching index; 0 on miss
//  RspAck     in   1       consumer accepts result
// BEHAVIOUR
//  Reset (Reset_n=0 at edge): FSM->IDLE; RspValid=0, RspHit=0, RspAddr=0; ReqReady=1 after reset.
//  Reset also restores the table: entries 0..7 = 19,27,34,39,51,74,76,83, valid; entries 8..31 = 0, invalid.
//  Reset mid-search or mid-response aborts; no response is produced for the aborted request.
//  FSM IDLE -> SEARCH on edge with ReqValid&ReqReady:
//   - latch key from ReqTarget; idx=0.
//  SEARCH: one entry per cycle, compare valid[idx] && table[idx]==key.
//   - match -> DONE, RspHit=1, RspAddr=idx.
//   - no match, idx==DEPTH-1 -> DONE, RspHit=0, RspAddr=0.
//   - else idx++. Counter never wraps.
//  DONE: RspValid=1, outputs stable; RspAck at edge -> IDLE, RspValid=0.
//   - Next request is accepted no earlier than the following edge.
//  Latency: hit at index k -> RspValid high k+1 edges after the accept edge. Miss -> DEPTH edges.
//  ReqValid while not IDLE is ignored (ReqReady=0); requester must hold.
//  RspAck outside DONE is ignored.
//  Lowest index wins on duplicate targets. Invalid entries never match, even when key==0.
//  Writes:
//   - WrEn at edge: table[WrAddr]=WrTarget, valid[WrAddr]=WrValid. Legal in any FSM state.
//   - A same-cycle write to the entry under compare: the compare uses the pre-write value.
//   - Writes to already-scanned entries do not affect the current search.
//   - Write + Reset_n=0 in the same cycle: reset wins.
//  RdTarget is purely combinational on RdAddr and stored state.
//   - Reflects a write from the edge after it.
//  Width rules: compare is full TGT_W equality; no truncation or extension.
// STRUCTURE
//  Package lut_pkg: ADDR_W, TGT_W, DEPTH, default-target constant array.
//   - FSM state encoding: IDLE=2'b00, SEARCH=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
//  Sub-module target_table: storage, valid bits, reset preload, write port, comb read by index.
//   - Used twice: forward RdAddr and search idx.
//  Top level: FSM, idx counter, key register, response registers.
// TESTING
//  1. Reset, ReqTarget=51 -> RspHit=1, RspAddr=4; RspValid 5 edges after accept.
//  2. ReqTarget=500 -> RspHit=0, RspAddr=0 after 32 edges.
//  3. ReqTarget=0 after reset -> miss. Write entry 9 = 0 valid, retry -> hit, RspAddr=9.
//  4. Write entry 2 = 83, search 83 -> RspAddr=2.
//     Then invalidate entry 2, search 83 -> RspAddr=7.
//  5. Hold RspAck=0 for 10 cycles -> RspValid/RspAddr stable, ReqReady=0, new ReqValid ignored.
//     Then ack -> IDLE.
//  6. Assert Reset_n=0 at idx=3 of a search for 83 -> no RspValid; table defaults back.
//     RdAddr=7 -> RdTarget=83.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared widths, FSM encoding and reset-time branch targets
// for the reverse target lookup.
package lut_pkg;

  localparam int ADDR_W = 5;
  localparam int TGT_W  = 11;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int N_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SEARCH = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  // Element 0 is the rightmost entry.
  localparam logic [N_DEF-1:0][TGT_W-1:0] DEF_TGT = {
    11'd83, 11'd76, 11'd74, 11'd51,
    11'd39, 11'd34, 11'd27, 11'd19
  };

  function automatic logic [TGT_W-1:0] def_tgt(input int i);
    if (i < N_DEF)
      return DEF_TGT[i[2:0]];
    return '0;
  endfunction

endpackage

// File: rtl/lut_reverse_search_target_table.sv
// Writable target table with valid bits, reset preload,
// one write port and two combinational read ports.
module target_table
  import lut_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              i_wr_en,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [TGT_W-1:0]  i_wr_target,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  output logic [TGT_W-1:0]  o_rd_target_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [TGT_W-1:0]  o_rd_target_b,
  output logic              o_rd_valid_b
);

  logic [TGT_W-1:0] r_tgt [DEPTH];
  logic [DEPTH-1:0] r_vld;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tgt[i] <= def_tgt(i);
        r_vld[i] <= (i < N_DEF);
      end
    end else if (i_wr_en) begin
      r_tgt[i_wr_addr] <= i_wr_target;
      r_vld[i_wr_addr] <= i_wr_valid;
    end
  end

  assign o_rd_target_a = r_vld[i_rd_addr_a]
                       ? r_tgt[i_rd_addr_a] : '0;
  assign o_rd_target_b = r_tgt[i_rd_addr_b];
  assign o_rd_valid_b  = r_vld[i_rd_addr_b];

endmodule

// File: rtl/lut_reverse_search.sv
// Reverse lookup: sequentially scans the target table for a key
// and reports the lowest matching index.
module lut_reverse_search
  import lut_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              WrEn,
  input  logic              WrValid,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [TGT_W-1:0]  WrTarget,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [TGT_W-1:0]  RdTarget,
  input  logic              ReqValid,
  input  logic [TGT_W-1:0]  ReqTarget,
  output logic              ReqReady,
  output logic              RspValid,
  output logic              RspHit,
  output logic [ADDR_W-1:0] RspAddr,
  input  logic              RspAck
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [TGT_W-1:0]  r_key;
  logic              r_rsp_valid;
  logic              r_hit;
  logic [ADDR_W-1:0] r_addr;

  logic [TGT_W-1:0]  w_cmp_tgt;
  logic              w_cmp_vld;
  logic              w_match;
  logic              w_last;

  target_table u_table (
    .CLK           (CLK),
    .Reset_n       (Reset_n),
    .i_wr_en       (WrEn),
    .i_wr_valid    (WrValid),
    .i_wr_addr     (WrAddr),
    .i_wr_target   (WrTarget),
    .i_rd_addr_a   (RdAddr),
    .o_rd_target_a (RdTarget),
    .i_rd_addr_b   (r_idx),
    .o_rd_target_b (w_cmp_tgt),
    .o_rd_valid_b  (w_cmp_vld)
  );

  // Table reads are pre-write, so a same-cycle write is not seen.
  assign w_match = w_cmp_vld && (w_cmp_tgt == r_key);
  assign w_last  = (r_idx == ADDR_W'(DEPTH - 1));

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_key       <= '0;
      r_rsp_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_addr      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ReqValid) begin
            r_key   <= ReqTarget;
            r_idx   <= '0;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_match) begin
            r_hit       <= 1'b1;
            r_addr      <= r_idx;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_last) begin
            r_hit       <= 1'b0;
            r_addr      <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (RspAck) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign ReqReady = (r_state == S_IDLE);
  assign RspValid = r_rsp_valid;
  assign RspHit   = r_hit;
  assign RspAddr  = r_addr;

endmodule

// File: tb/tb_lut_reverse_search.sv
// Randomized bench for lut_reverse_search against an
// array-based model of the target table.
module tb_lut_reverse_search;
  import lut_pkg::*;

  logic              CLK = 0;
  logic              Reset_n;
  logic              WrEn, WrValid;
  logic [ADDR_W-1:0] WrAddr, RdAddr, RspAddr;
  logic [TGT_W-1:0]  WrTarget, RdTarget, ReqTarget;
  logic              ReqValid, ReqReady;
  logic              RspValid, RspHit, RspAck;

  int n_checks = 0;
  int n_pass   = 0;

  int m_tgt [DEPTH];
  bit m_vld [DEPTH];

  lut_reverse_search dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .WrEn(WrEn), .WrValid(WrValid),
    .WrAddr(WrAddr), .WrTarget(WrTarget),
    .RdAddr(RdAddr), .RdTarget(RdTarget),
    .ReqValid(ReqValid), .ReqTarget(ReqTarget),
    .ReqReady(ReqReady), .RspValid(RspValid),
    .RspHit(RspHit), .RspAddr(RspAddr),
    .RspAck(RspAck)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    int defs [8] = '{19, 27, 34, 39, 51, 74, 76, 83};
    for (int i = 0; i < DEPTH; i++) begin
      m_tgt[i] = (i < 8) ? defs[i] : 0;
      m_vld[i] = (i < 8);
    end
  endtask

  // Lowest valid index holding key, -1 on miss.
  function automatic int model_find(input int key);
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i] && m_tgt[i] == key) return i;
    return -1;
  endfunction

  task automatic do_reset();
    Reset_n = 0;
    repeat (2) @(posedge CLK);
    #1 Reset_n = 1;
    model_reset();
  endtask

  task automatic do_write(input int a, input int t,
                          input bit v);
    WrEn = 1; WrAddr = a[ADDR_W-1:0];
    WrTarget = t[TGT_W-1:0]; WrValid = v;
    @(posedge CLK); #1;
    WrEn = 0;
    m_tgt[a] = t; m_vld[a] = v;
  endtask

  // Issue request, count edges to RspValid, leave response pending.
  task automatic start_wait(input int key, output int lat);
    ReqValid = 1; ReqTarget = key[TGT_W-1:0];
    @(posedge CLK); #1;
    ReqValid = 0;
    lat = 0;
    while (!RspValid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic do_ack();
    RspAck = 1;
    @(posedge CLK); #1;
    RspAck = 0;
  endtask

  task automatic check_search(input string nm, input int key);
    int lat, exp_i, exp_lat;
    bit exp_hit;
    logic [ADDR_W-1:0] exp_a;
    exp_i   = model_find(key);
    exp_hit = (exp_i >= 0);
    exp_a   = exp_hit ? exp_i[ADDR_W-1:0] : '0;
    exp_lat = exp_hit ? exp_i + 1 : DEPTH;
    start_wait(key, lat);
    n_checks++;
    if (lat !== exp_lat)
      $display("FAIL %s latency key=%0d got %0d exp %0d",
               nm, key, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (RspHit !== exp_hit || RspAddr !== exp_a)
      $display("FAIL %s result key=%0d got hit=%b addr=%0d exp hit=%b addr=%0d",
               nm, key, RspHit, RspAddr, exp_hit, exp_a);
    else n_pass++;
    do_ack();
    n_checks++;
    if (RspValid !== 1'b0 || ReqReady !== 1'b1)
      $display("FAIL %s ack got valid=%b ready=%b exp 0/1",
               nm, RspValid, ReqReady);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (RspValid !== 0 || RspHit !== 0 || RspAddr !== 0 ||
        ReqReady !== 1)
      $display("FAIL reset got v=%b h=%b a=%0d r=%b exp 0/0/0/1",
               RspValid, RspHit, RspAddr, ReqReady);
    else n_pass++;
    for (int i = 0; i < 10; i += 3) begin
      RdAddr = i[ADDR_W-1:0]; #1;
      n_checks++;
      if (RdTarget !== TGT_W'(m_tgt[i]))
        $display("FAIL reset_rd[%0d] got %0d exp %0d",
                 i, RdTarget, m_tgt[i]);
      else n_pass++;
    end
  endtask

  task automatic test_defaults();
    check_search("hit51", 51);
    check_search("miss500", 500);
  endtask

  task automatic test_zero_key();
    check_search("zero_miss", 0);
    do_write(9, 0, 1);
    check_search("zero_hit9", 0);
  endtask

  task automatic test_duplicate();
    do_write(2, 83, 1);
    check_search("dup_low", 83);
    do_write(2, 83, 0);
    check_search("dup_inval", 83);
  endtask

  task automatic test_hold();
    int lat;
    bit bad = 0;
    start_wait(51, lat);
    ReqValid = 1; ReqTarget = 11'd19;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (RspValid !== 1 || RspAddr !== 4 || RspHit !== 1 ||
          ReqReady !== 0) bad = 1;
    end
    n_checks++;
    if (bad)
      $display("FAIL hold got v=%b h=%b a=%0d r=%b exp 1/1/4/0",
               RspValid, RspHit, RspAddr, ReqReady);
    else n_pass++;
    ReqValid = 0;
    do_ack();
    n_checks++;
    if (RspValid !== 0 || ReqReady !== 1)
      $display("FAIL hold_ack got v=%b r=%b exp 0/1",
               RspValid, ReqReady);
    else n_pass++;
  endtask

  // Write to an already-scanned entry mid-search must not matter.
  task automatic test_scanned_write();
    int lat;
    do_write(10, 1234, 1);
    ReqValid = 1; ReqTarget = 11'd1234;
    @(posedge CLK); #1;
    ReqValid = 0;
    repeat (5) @(posedge CLK);
    #1;
    WrEn = 1; WrAddr = 3; WrTarget = 11'd1234; WrValid = 1;
    @(posedge CLK); #1;
    WrEn = 0;
    lat = 6;
    while (!RspValid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 11 || RspAddr !== 10 || RspHit !== 1)
      $display("FAIL scanned_wr got lat=%0d a=%0d h=%b exp 11/10/1",
               lat, RspAddr, RspHit);
    else n_pass++;
    do_ack();
    m_tgt[3] = 1234; m_vld[3] = 1;
    check_search("after_wr", 1234);
  endtask

  task automatic test_reset_abort();
    bit seen = 0;
    ReqValid = 1; ReqTarget = 11'd83;
    @(posedge CLK); #1;
    ReqValid = 0;
    repeat (3) @(posedge CLK);
    #1;
    Reset_n = 0;
    WrEn = 1; WrAddr = 7; WrTarget = 11'd5; WrValid = 1;
    @(posedge CLK); #1;
    Reset_n = 1; WrEn = 0;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      if (RspValid !== 0) seen = 1;
      @(posedge CLK); #1;
    end
    n_checks++;
    if (seen || ReqReady !== 1)
      $display("FAIL abort got seen=%b r=%b exp 0/1",
               seen, ReqReady);
    else n_pass++;
    RdAddr = 7; #1;
    n_checks++;
    if (RdTarget !== 11'd83)
      $display("FAIL abort_rd7 got %0d exp 83", RdTarget);
    else n_pass++;
    RdAddr = 9; #1;
    n_checks++;
    if (RdTarget !== 0)
      $display("FAIL abort_rd9 got %0d exp 0", RdTarget);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int a, t, key, r;
      a = $urandom_range(DEPTH - 1);
      t = $urandom_range(15);
      do_write(a, t, $urandom_range(3) != 0);
      r = $urandom_range(DEPTH - 1);
      RdAddr = r[ADDR_W-1:0]; #1;
      n_checks++;
      if (RdTarget !== (m_vld[r] ? TGT_W'(m_tgt[r]) : '0))
        $display("FAIL rand_rd[%0d] got %0d exp %0d", r,
                 RdTarget, m_vld[r] ? m_tgt[r] : 0);
      else n_pass++;
      key = $urandom_range(1) ? $urandom_range(15)
                              : $urandom_range(2047);
      check_search("rand", key);
    end
  endtask

  initial begin
    Reset_n = 0; WrEn = 0; WrValid = 0; WrAddr = 0;
    WrTarget = 0; RdAddr = 0; ReqValid = 0;
    ReqTarget = 0; RspAck = 0;
    model_reset();
    test_reset();
    test_defaults();
    test_zero_key();
    test_duplicate();
    test_hold();
    test_scanned_write();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
